// File: rtl/led_activity_stretcher.sv
// Per-channel LED flash stretcher: each event strobe becomes a fixed ON window
// followed by a mandatory OFF gap, with at most one flash queued behind it.
module led_activity_stretcher #(
  parameter int CHANNELS = 4,
  parameter int ON_CLKS  = 2500000,
  parameter int OFF_CLKS = 2500000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CHANNELS-1:0] i_event,
  output logic [CHANNELS-1:0] o_led,
  output logic                o_busy
);

  localparam int MAX_CLKS = (ON_CLKS > OFF_CLKS) ? ON_CLKS : OFF_CLKS;
  localparam int CNT_W    = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CLKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // Power-up values give a dark, idle indicator even without a reset pulse.
  state_t [CHANNELS-1:0]            state_r = {CHANNELS{ST_IDLE}};
  logic   [CHANNELS-1:0][CNT_W-1:0] cnt_r   = '0;
  logic   [CHANNELS-1:0]            pend_r  = '0;
  logic   [CHANNELS-1:0]            led_r   = '0;
  logic                             busy_r  = 1'b0;

  state_t [CHANNELS-1:0]            nxt_state_s;
  logic   [CHANNELS-1:0][CNT_W-1:0] nxt_cnt_s;
  logic   [CHANNELS-1:0]            nxt_pend_s;
  logic   [CHANNELS-1:0]            nxt_led_s;
  logic                             nxt_busy_s;

  // Next-state decode for every channel, plus the output values it implies.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_pend_s  = pend_r;
    nxt_led_s   = '0;
    nxt_busy_s  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      case (state_r[k])
        ST_IDLE: begin
          if (i_event[k]) begin
            nxt_state_s[k] = ST_ON;
            nxt_cnt_s[k]   = '0;
          end else begin
            nxt_cnt_s[k]   = '0;
          end
        end
        ST_ON: begin
          nxt_pend_s[k] = pend_r[k] | i_event[k];
          if (cnt_r[k] == ON_LAST) begin
            nxt_state_s[k] = ST_OFF;
            nxt_cnt_s[k]   = '0;
          end else begin
            nxt_cnt_s[k]   = cnt_r[k] + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (cnt_r[k] == OFF_LAST) begin
            // An event on the last gap cycle chains straight into the next flash.
            if (pend_r[k] | i_event[k]) begin
              nxt_state_s[k] = ST_ON;
            end else begin
              nxt_state_s[k] = ST_IDLE;
            end
            nxt_cnt_s[k]  = '0;
            nxt_pend_s[k] = 1'b0;
          end else begin
            nxt_cnt_s[k]  = cnt_r[k] + CNT_W'(1);
            nxt_pend_s[k] = pend_r[k] | i_event[k];
          end
        end
        default: begin
          nxt_state_s[k] = ST_IDLE;
          nxt_cnt_s[k]   = '0;
          nxt_pend_s[k]  = 1'b0;
        end
      endcase
      nxt_led_s[k] = (nxt_state_s[k] == ST_ON);
      nxt_busy_s   = nxt_busy_s | (nxt_state_s[k] != ST_IDLE);
    end
  end

  // State, counters and both outputs registered together; reset wins over events.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= {CHANNELS{ST_IDLE}};
      cnt_r   <= '0;
      pend_r  <= '0;
      led_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      pend_r  <= nxt_pend_s;
      led_r   <= nxt_led_s;
      busy_r  <= nxt_busy_s;
    end
  end

  assign o_led  = led_r;
  assign o_busy = busy_r;

endmodule

// File: tb/tb_led_activity_stretcher.sv
// Scoreboard bench for led_activity_stretcher with CHANNELS=2, ON_CLKS=4, OFF_CLKS=3.
module tb_led_activity_stretcher;

  localparam int CH  = 2;
  localparam int ON  = 4;
  localparam int OFF = 3;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [CH-1:0] i_event = '0;
  logic [CH-1:0] o_led;
  logic          o_busy;

  led_activity_stretcher #(.CHANNELS(CH), .ON_CLKS(ON), .OFF_CLKS(OFF)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_event(i_event),
    .o_led  (o_led),
    .o_busy (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [CH-1:0] led;
    logic          busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference: position within the ON+OFF period (0 = idle, 1..ON lit, ON+1..ON+OFF dark).
  int   phase_m [CH];
  logic pend_m  [CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] stim(input int scen, input int c);
    logic [CH-1:0] ev;
    ev = '0;
    case (scen)
      0: ev[0] = (c == 10);
      1: ev[0] = (c == 10) || (c == 12) || (c == 13);
      2: ev[0] = (c >= 10) && (c < 40);
      3: ev[0] = (c == 10) || (c == 17);
      4: ev[0] = (c == 10) || (c == 18);
      5: ev[0] = (c == 10) || (c == 12);
      6: begin
        ev[0] = (c == 10);
        ev[1] = (c == 10) || (c == 12);
      end
      default: ev = '0;
    endcase
    return ev;
  endfunction

  task automatic model_edge(input logic [CH-1:0] ev, input logic rst);
    exp_t e;
    e.led  = '0;
    e.busy = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (rst) begin
        phase_m[k] = 0;
        pend_m[k]  = 1'b0;
      end else if (phase_m[k] == 0) begin
        if (ev[k]) phase_m[k] = 1;
      end else if (phase_m[k] == ON + OFF) begin
        phase_m[k] = (pend_m[k] || ev[k]) ? 1 : 0;
        pend_m[k]  = 1'b0;
      end else begin
        phase_m[k] = phase_m[k] + 1;
        if (ev[k]) pend_m[k] = 1'b1;
      end
      e.led[k] = (phase_m[k] >= 1) && (phase_m[k] <= ON);
      if (phase_m[k] != 0) e.busy = 1'b1;
    end
    sb_q.push_back(e);
  endtask

  task automatic directed(input int scen, input int c);
    case (scen)
      0: begin
        if (c == 14) chk("s0_led_c14", o_led[0], 1);
        if (c == 15) chk("s0_led_c15", o_led[0], 0);
        if (c == 17) chk("s0_busy_c17", o_busy, 1);
        if (c == 18) chk("s0_busy_c18", o_busy, 0);
      end
      1: begin
        if (c == 18) chk("s1_led_c18", o_led[0], 1);
        if (c == 21) chk("s1_led_c21", o_led[0], 1);
        if (c == 22) chk("s1_led_c22", o_led[0], 0);
        if (c == 24) chk("s1_busy_c24", o_busy, 1);
        if (c == 25) chk("s1_busy_c25", o_busy, 0);
      end
      2: begin
        if (c == 11) chk("s2_led_c11", o_led[0], 1);
        if (c == 15) chk("s2_led_c15", o_led[0], 0);
        if (c == 18) chk("s2_led_c18", o_led[0], 1);
      end
      3: if (c == 18) chk("s3_led_c18", o_led[0], 1);
      4: begin
        if (c == 18) chk("s4_led_c18", o_led[0], 0);
        if (c == 19) chk("s4_led_c19", o_led[0], 1);
      end
      5: begin
        if (c == 13) chk("s5_led_c13", o_led[0], 0);
        if (c == 13) chk("s5_busy_c13", o_busy, 0);
        if (c == 20) chk("s5_busy_c20", o_busy, 0);
      end
      6: begin
        if (c == 19) chk("s6_led0_c19", o_led[0], 0);
        if (c == 19) chk("s6_led1_c19", o_led[1], 1);
        if (c == 24) chk("s6_busy_c24", o_busy, 1);
      end
      default: ;
    endcase
  endtask

  task automatic run_scen(input int scen, input int ncyc);
    exp_t          e;
    logic [CH-1:0] ev;
    logic          rst;
    for (int c = 0; c < ncyc; c++) begin
      e = sb_q.pop_front();
      chk($sformatf("s%0d_c%0d_led", scen, c), o_led, e.led);
      chk($sformatf("s%0d_c%0d_busy", scen, c), o_busy, e.busy);
      directed(scen, c);
      ev  = stim(scen, c);
      rst = (c < 2) || (scen == 5 && c == 12);
      i_event = ev;
      i_rst   = rst;
      model_edge(ev, rst);
      @(negedge i_clk);
    end
  endtask

  initial begin
    exp_t e0;
    for (int k = 0; k < CH; k++) begin
      phase_m[k] = 0;
      pend_m[k]  = 1'b0;
    end
    e0.led  = '0;
    e0.busy = 1'b0;
    sb_q.push_back(e0);
    @(negedge i_clk);
    for (int s = 0; s < 7; s++) begin
      run_scen(s, (s == 2) ? 60 : 35);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
